// File: rtl/alu_exec_stage.sv
// EX-stage ALU for the 4-bit control code, with the result and its zero/illegal flags registered.
// A two-entry output stage (out reg + skid) gives 1 cycle latency, and in_ready comes only from registers.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_cntrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_res;
  logic            r_zero;
  logic            r_ill;
  logic [XLEN-1:0] r_sk_res;
  logic            r_sk_zero;
  logic            r_sk_ill;

  logic [XLEN-1:0] w_res;
  logic            w_ill;
  logic            w_zero;
  logic            w_acc;
  logic            w_del;

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (alu_cntrl)
      OP_AND:  w_res = src_a & src_b;
      OP_OR:   w_res = src_a | src_b;
      OP_ADD:  w_res = src_a + src_b;
      OP_SUB:  w_res = src_a - src_b;
      default: w_ill = 1'b1;
    endcase
  end

  assign w_zero = (w_res == '0);
  assign w_acc  = in_valid & r_in_ready;
  assign w_del  = r_out_valid & out_ready;

  // Result payload is not cleared on delivery; only out_valid tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_ill       <= 1'b0;
      r_sk_res    <= '0;
      r_sk_zero   <= 1'b0;
      r_sk_ill    <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_res       <= w_res;
            r_zero      <= w_zero;
            r_ill       <= w_ill;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_acc && w_del) begin
            r_res  <= w_res;
            r_zero <= w_zero;
            r_ill  <= w_ill;
          end else if (w_acc) begin
            r_sk_res   <= w_res;
            r_sk_zero  <= w_zero;
            r_sk_ill   <= w_ill;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (w_del) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_del) begin
            r_res      <= r_sk_res;
            r_zero     <= r_sk_zero;
            r_ill      <= r_sk_ill;
            r_sk_res   <= '0;
            r_sk_zero  <= 1'b0;
            r_sk_ill   <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_res;
  assign zero       = r_zero;
  assign illegal    = r_ill;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a driver pushes the expected results, and a separate monitor pops them and checks each delivery.
module tb_alu_exec_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_cntrl = 4'd0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            illegal;

  int total = 0;
  int bad = 0;
  int del_cnt = 0;
  logic rnd_rdy = 1'b0;
  logic rdy_fixed = 1'b0;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            z;
    logic            ill;
  } exp_t;

  exp_t sb[$];

  alu_exec_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_cntrl(alu_cntrl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    longint unsigned full;
    e.ill = 1'b0;
    e.res = '0;
    if (c == 4'd0)      e.res = a & b;
    else if (c == 4'd1) e.res = a | b;
    else if (c == 4'd2) begin full = longint'(a) + longint'(b); e.res = full[XLEN-1:0]; end
    else if (c == 4'd6) begin full = (longint'(1) << XLEN) + longint'(a) - longint'(b); e.res = full[XLEN-1:0]; end
    else e.ill = 1'b1;
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // The monitor samples at posedge+3; whatever it sees is what the next edge delivers.
  logic            held_vld = 1'b0;
  logic [XLEN-1:0] held_res;
  logic            held_z, held_ill;
  always @(posedge clk) begin
    exp_t e;
    #3;
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld && out_valid) begin
        check("stall_hold", {alu_result, zero, illegal}, {held_res, held_z, held_ill});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", alu_result, e.res);
          check("zero", 32'(zero), 32'(e.z));
          check("illegal", 32'(illegal), 32'(e.ill));
        end
        del_cnt++;
      end
      held_vld = out_valid && !out_ready;
      held_res = alu_result;
      held_z = zero;
      held_ill = illegal;
    end
  end

  task automatic send(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int w;
    w = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_cntrl = c; src_a = a; src_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(c, a, b));
        break;
      end
      w++;
      if (w > 50) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0;
    logic [3:0] c;
    logic [XLEN-1:0] a, b;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    rdy_fixed = 1'b1;

    // Directed operations
    send(4'b0010, 32'd5, 32'd7);
    idle();
    @(negedge clk);
    check("add_latency_valid", 32'(out_valid), 32'd1);
    check("add_value", alu_result, 32'd12);
    send(4'b0110, 32'h10, 32'h10);
    send(4'b0110, 32'h0, 32'h1);
    send(4'b0000, 32'hF0F0, 32'h0FF0);
    send(4'b0001, 32'hF000, 32'h000F);
    send(4'b1111, 32'h1234, 32'h5678);
    send(4'b0011, 32'hFFFF_FFFF, 32'h1);
    send(4'b0010, 32'hFFFF_FFFF, 32'h1);
    idle();
    drain();

    // Stall: two ops fill the stage, then it drains in order on consecutive cycles
    @(posedge clk); #1; rdy_fixed = 1'b0;
    send(4'b0010, 32'd100, 32'd1);
    send(4'b0110, 32'd100, 32'd1);
    idle();
    @(negedge clk);
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("stall_still_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1; rdy_fixed = 1'b1;
    d0 = del_cnt;
    @(posedge clk); #5;
    check("stall_deliver_two", 32'(del_cnt - d0), 32'd2);
    check("stall_in_ready_back", 32'(in_ready), 32'd1);
    drain();

    // Random traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      case ($urandom_range(0, 5))
        0: c = 4'b0000;
        1: c = 4'b0001;
        2: c = 4'b0010;
        3: c = 4'b0110;
        4: c = 4'b0110;
        default: c = 4'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(c, a, b);
    end
    idle();
    rnd_rdy = 1'b0;
    rdy_fixed = 1'b1;
    drain();

    // Reset with both entries occupied
    @(posedge clk); #1; rdy_fixed = 1'b0;
    send(4'b0010, 32'd1, 32'd2);
    send(4'b0010, 32'd3, 32'd4);
    idle();
    @(negedge clk);
    check("pre_reset_full", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", alu_result, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    rdy_fixed = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    send(4'b0001, 32'hA0, 32'h0B);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
